wb_commit_unit: RTL
===================

# wb_commit_unit

Write-back commit unit that drives the integer register file's write port (`RegWrite`/`WriteAddr`/`WriteData`) from two result producers: the ALU and the load unit. It arbitrates between them, buffering ALU results while a load commits. It also keeps a per-register pending scoreboard that the decode stage queries before reading rs1/rs2. It sits between EX/MEM and the register file, as the writer side of the register file interface.

## Interface
- `XLEN`, 64, data width; matches register width.
- `REG_NUM`, 32, number of architectural registers.
- `ADDR_W`, 5, register address width (log2 `REG_NUM`).
- `FIFO_DEPTH`, 2, ALU result buffer entries (power of two, ≥2).

Ports:
- `sys_clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `iss_valid`  in  1  instruction with a destination issued this cycle.
- `iss_rd`  in  ADDR_W  destination of the issued instruction.
- `alu_valid`  in  1  ALU result offered.
- `alu_rd`  in  ADDR_W  ALU destination.
- `alu_data`  in  XLEN  ALU result.
- `alu_ready`  out  1  ALU result accepted when `alu_valid && alu_ready`.
- `ld_valid`  in  1  load result offered.
- `ld_rd`  in  ADDR_W  load destination.
- `ld_data`  in  XLEN  load result.
- `ld_ready`  out  1  load result accepted when `ld_valid && ld_ready`.
- `RegWrite`  out  1  register-file write enable (registered).
- `WriteAddr`  out  ADDR_W  register-file write address (registered).
- `WriteData`  out  XLEN  register-file write data (registered).
- `chk_rs1`, `chk_rs2`  in  ADDR_W  decode-stage source queries.
- `rs1_busy`, `rs2_busy`  out  1  source has an uncommitted write.

## Operation
- Loads have strict priority and no buffer. `ld_ready = !rst`.
- ALU results pass through a `FIFO_DEPTH` FIFO. `alu_ready = !rst && !fifo_full`. `alu_ready` depends only on state, never on `ld_valid`.
- Per-cycle commit source, in priority order:
  - an accepted load;
  - else the FIFO head (pop);
  - else an accepted ALU result when the FIFO is empty (bypass, no enqueue).
- An accepted ALU result that is not consumed by bypass is enqueued. Push and pop in the same cycle are legal. Read/write pointers wrap modulo `FIFO_DEPTH`, with an extra bit for full/empty.
- Results with rd == 0 are accepted and discarded. They are never enqueued, never assert `RegWrite`, and do not consume the commit slot.
- Commit register: `RegWrite <= 1`, `WriteAddr <= rd`, `WriteData <= data` when a source is selected. Otherwise `RegWrite <= 0`, and address/data hold their previous values.
- Scoreboard: `pending[REG_NUM]`.
  - Set on `iss_valid` with `iss_rd != 0`.
  - Cleared when `RegWrite && WriteAddr == r`.
  - A same-cycle set and clear of the same register resolves to set.
  - `pending[0]` is never set.
- `rsN_busy = pending[chk_rsN] && !(RegWrite && WriteAddr == chk_rsN)`. This relies on the register file's same-cycle write bypass. `chk == 0` always gives busy = 0.
- Upstream guarantees no issue to an already-pending rd (WAW stall). A simulation-only assertion flags any violation.

## Timing
- Reset (while `rst` is high, next edge):
  - `RegWrite`, `WriteAddr`, `WriteData` = 0.
  - FIFO empty, `pending` all 0.
  - `alu_ready` = 0 and `ld_ready` = 0 during reset.
- Reset mid-operation discards buffered ALU results and pending bits.
- Latency:
  - load accepted at cycle N → `RegWrite` at N+1;
  - ALU bypass at N → N+1;
  - buffered ALU result → one cycle after the first cycle with no accepted load and it at the FIFO head.
- Commit order per source is preserved (FIFO order). No ordering is guaranteed between ALU and load results.
- Continuous `ld_valid` starves the FIFO. Once full, `alu_ready` stays 0 until a free cycle.
- Busy outputs are combinational from registered state plus `chk_*`. There is no path from `*_valid` to `*_ready`.

## Structure
- Shared package `wb_pkg`: `XLEN`, `REG_NUM`, `ADDR_W`, result struct type `wb_result_t {rd, data}`, and the enable/reset level constants already used by the register file.
- One sub-module: `wb_result_fifo`, parameterized by depth and element type. It provides push/pop/full/empty.
- Arbitration, commit register and scoreboard stay in the top module.

## Test plan
- Reset: assert `rst` for 2 cycles with `ld_valid=1` → `ld_ready=0`, `alu_ready=0`, `RegWrite=0`, `WriteAddr=0`, `WriteData=0`, all busy 0.
- Bypass: ALU rd=5, data=0x1234 alone at N → N+1 `RegWrite=1`, `WriteAddr=5`, `WriteData=0x1234`; FIFO stays empty.
- Conflict: ALU (rd=3, 0xA) and load (rd=4, 0xB) together, then load (rd=6, 0xC) → commits 4/0xB, 6/0xC, then 3/0xA; `alu_ready=0` once 2 ALU results are buffered.
- x0: load rd=0 with ALU rd=7 the same cycle → only 7 commits, next cycle; `RegWrite` is never seen with `WriteAddr=0`.
- Scoreboard: issue rd=9 → `rs1_busy=1` for `chk_rs1=9`; on the commit cycle of rd=9 busy=0; after it, busy stays 0. `chk_rs2=0` is always 0.
- Simultaneous: issue rd=9 the same cycle rd=9 commits → `pending[9]` remains 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared write-back definitions: register file geometry, the result record
// carried from producers to the commit register, and enable/reset levels.
package wb_pkg;

  localparam int XLEN    = 64;
  localparam int REG_NUM = 32;
  localparam int ADDR_W  = 5;

  // Levels shared with the register file write port and reset network
  localparam logic WE_ON  = 1'b1;
  localparam logic WE_OFF = 1'b0;
  localparam logic RST_ON = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_result_t;

  // Writes to x0 are architecturally discarded
  function automatic logic is_x0(input logic [ADDR_W-1:0] rd);
    return rd == '0;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small power-of-two FIFO for pending ALU results; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_result_t
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  T mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign pop_data = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge sys_clk) begin
    if (rst == RST_ON) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Register-file write port arbiter: loads win, ALU results are buffered or
// bypassed, and a per-register pending scoreboard answers decode queries.
module wb_commit_unit
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic              ld_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [XLEN-1:0]   WriteData,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic [ADDR_W-1:0] chk_rs2,
  output logic              rs1_busy,
  output logic              rs2_busy
);

  logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_result_t   fifo_head, alu_res, ld_res, commit_res;
  logic         ld_live, alu_live, commit_valid;
  logic [REG_NUM-1:0] pending, set_mask, clr_mask;

  assign ld_ready  = (rst != RST_ON);
  assign alu_ready = (rst != RST_ON) && !fifo_full;

  // x0 results are accepted but never reach the commit slot or the buffer
  assign ld_live  = ld_valid && ld_ready && !is_x0(ld_rd);
  assign alu_live = alu_valid && alu_ready && !is_x0(alu_rd);

  assign alu_res = '{rd: alu_rd, data: alu_data};
  assign ld_res  = '{rd: ld_rd, data: ld_data};

  always_comb begin
    commit_valid = 1'b0;
    commit_res   = '0;
    fifo_pop     = 1'b0;
    if (ld_live) begin
      commit_valid = 1'b1;
      commit_res   = ld_res;
    end else if (!fifo_empty) begin
      commit_valid = 1'b1;
      commit_res   = fifo_head;
      fifo_pop     = 1'b1;
    end else if (alu_live) begin
      commit_valid = 1'b1;
      commit_res   = alu_res;
    end
    fifo_push = alu_live && (ld_live || !fifo_empty);
  end

  wb_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (wb_result_t)
  ) u_alu_fifo (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (alu_res),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge sys_clk) begin
    if (rst == RST_ON) begin
      RegWrite  <= WE_OFF;
      WriteAddr <= '0;
      WriteData <= '0;
    end else if (commit_valid) begin
      RegWrite  <= WE_ON;
      WriteAddr <= commit_res.rd;
      WriteData <= commit_res.data;
    end else begin
      RegWrite  <= WE_OFF;
    end
  end

  // A new issue outranks the retiring write of the same register
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && !is_x0(iss_rd)) set_mask[iss_rd] = 1'b1;
    if (RegWrite == WE_ON) clr_mask[WriteAddr] = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (rst == RST_ON) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  assign rs1_busy = pending[chk_rs1] && !((RegWrite == WE_ON) && (WriteAddr == chk_rs1));
  assign rs2_busy = pending[chk_rs2] && !((RegWrite == WE_ON) && (WriteAddr == chk_rs2));

  // Upstream must stall a write-after-write until the older write retires
  waw_guard: assert property (@(posedge sys_clk) disable iff (rst == RST_ON)
    (iss_valid && !is_x0(iss_rd)) |->
      (!pending[iss_rd] || ((RegWrite == WE_ON) && (WriteAddr == iss_rd))));

endmodule
